// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master Wishbone arbiter: grant FSM state
// encoding, master index constants, default watchdog sizing (shared with
// the 1-to-8 interconnect) and a helper that maps a grant state to the
// one-hot grant vector.
// ---------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;

    localparam int unsigned WB_ARB_TW      = 8;
    localparam int unsigned WB_ARB_TIMEOUT = 255;

    // One-hot grant for a state (bit0 = master 0); unknown encodings map to 00.
    function automatic logic [1:0] gnt_onehot(input arb_state_e st);
        logic [1:0] g;
        case (st)
            ST_GNT0: g = 2'b01;
            ST_GNT1: g = 2'b10;
            ST_IDLE: g = 2'b00;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_ack_watchdog.sv
// ---------------------------------------------------------------------------
// wb_ack_watchdog
// Counts cycles on which the granted master strobes without an ack. After
// TIMEOUT such cycles it raises err_pend for exactly one cycle and restarts.
// TIMEOUT = 0 removes the counter and ties err_pend low.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   stb         strobe of the granted master (already gated by its cyc)
//   ack         slave acknowledge
//   clr         grant is changing on the coming edge
//   err_pend    registered one-cycle timeout pulse
// ---------------------------------------------------------------------------
module wb_ack_watchdog
    import wb_arb_pkg::*;
#(
    parameter int unsigned TW      = WB_ARB_TW,
    parameter int unsigned TIMEOUT = WB_ARB_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    input  logic ack,
    input  logic clr,
    output logic err_pend
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_s;
            assign unused_s = &{1'b0, clk, rst_n, stb, ack, clr};
            assign err_pend = 1'b0;
        end else begin : g_on
            localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT - 1);
            localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};
            localparam logic [TW-1:0] CNT_ONE  = {{(TW-1){1'b0}}, 1'b1};

            logic [TW-1:0] wdog_r;
            logic          err_r;

            // Stall counter and err pulse; the pulse cycle itself restarts the count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wdog_r <= {TW{1'b0}};
                    err_r  <= 1'b0;
                end else if (err_r || clr || !stb || ack) begin
                    wdog_r <= {TW{1'b0}};
                    err_r  <= 1'b0;
                end else if (wdog_r == LAST_CNT) begin
                    wdog_r <= {TW{1'b0}};
                    err_r  <= 1'b1;
                end else if (wdog_r != CNT_MAX) begin
                    wdog_r <= wdog_r + CNT_ONE;
                    err_r  <= 1'b0;
                end else begin
                    wdog_r <= wdog_r;
                    err_r  <= 1'b0;
                end
            end

            assign err_pend = err_r;
        end
    endgenerate

endmodule

// File: rtl/wishbone_2mst_arbiter.sv
// ---------------------------------------------------------------------------
// wishbone_2mst_arbiter
// Shares one Wishbone slave port between master 0 (management core) and
// master 1 (on-chip sequencer). Round-robin on ties, bus locked to the owner
// while its CYC stays high, direct handoff when the owner releases, and an
// ack watchdog that returns ERR to the owner of a stalled transfer.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   m0_* / m1_*           master ports (cyc/stb/adr/we/dat/sel in;
//                         dat/ack/err out)
//   s_*                   slave port toward the interconnect
//   gnt_o                 registered one-hot grant, 00 when idle
// ---------------------------------------------------------------------------
module wishbone_2mst_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TW      = WB_ARB_TW,
    parameter int unsigned TIMEOUT = WB_ARB_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic [31:0] m0_adr_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic [31:0] m1_adr_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o
);

    arb_state_e state_r;
    arb_state_e state_next_s;
    logic       last_r;
    logic [1:0] gnt_r;
    logic       err_pend_s;
    logic       wd_stb_s;
    logic       grant_chg_s;
    logic       ack0_s;
    logic       ack1_s;

    // State register, last-served master and registered grant vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            last_r  <= M1_IDX;
            gnt_r   <= 2'b00;
        end else begin
            state_r <= state_next_s;
            gnt_r   <= gnt_onehot(state_next_s);
            if (state_next_s == ST_GNT0) begin
                last_r <= M0_IDX;
            end else if (state_next_s == ST_GNT1) begin
                last_r <= M1_IDX;
            end else begin
                last_r <= last_r;
            end
        end
    end

    // Next grant: re-arbitrate only when idle or when the owner has dropped CYC.
    always_comb begin
        logic decide_s;
        decide_s     = 1'b0;
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: decide_s = 1'b1;
            ST_GNT0: decide_s = ~m0_cyc_i;
            ST_GNT1: decide_s = ~m1_cyc_i;
            default: decide_s = 1'b1;
        endcase
        if (decide_s) begin
            if (m0_cyc_i && m1_cyc_i) begin
                // Tie goes to whoever was not served last.
                state_next_s = (last_r == M1_IDX) ? ST_GNT0 : ST_GNT1;
            end else if (m0_cyc_i) begin
                state_next_s = ST_GNT0;
            end else if (m1_cyc_i) begin
                state_next_s = ST_GNT1;
            end else begin
                state_next_s = ST_IDLE;
            end
        end else begin
            state_next_s = state_r;
        end
    end

    assign grant_chg_s = (state_next_s != state_r);
    assign ack0_s      = s_ack_i & m0_stb_i;
    assign ack1_s      = s_ack_i & m1_stb_i;

    // Bus muxing from the registered grant. A pending timeout pulls cyc/stb
    // low toward the slave for the err cycle; a late ack in that cycle still
    // wins over err so the master never sees both.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = 32'h0000_0000;
        s_dat_o  = 32'h0000_0000;
        s_sel_o  = 4'h0;
        m0_dat_o = 32'h0000_0000;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = 32'h0000_0000;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        wd_stb_s = 1'b0;
        case (state_r)
            ST_GNT0: begin
                s_cyc_o  = m0_cyc_i & ~err_pend_s;
                s_stb_o  = m0_cyc_i & m0_stb_i & ~err_pend_s;
                s_we_o   = m0_cyc_i & m0_we_i;
                s_adr_o  = m0_adr_i & {32{m0_cyc_i}};
                s_dat_o  = m0_dat_i & {32{m0_cyc_i}};
                s_sel_o  = m0_sel_i & {4{m0_cyc_i}};
                m0_dat_o = s_dat_i;
                m0_ack_o = ack0_s;
                m0_err_o = err_pend_s & ~ack0_s;
                wd_stb_s = m0_cyc_i & m0_stb_i;
            end
            ST_GNT1: begin
                s_cyc_o  = m1_cyc_i & ~err_pend_s;
                s_stb_o  = m1_cyc_i & m1_stb_i & ~err_pend_s;
                s_we_o   = m1_cyc_i & m1_we_i;
                s_adr_o  = m1_adr_i & {32{m1_cyc_i}};
                s_dat_o  = m1_dat_i & {32{m1_cyc_i}};
                s_sel_o  = m1_sel_i & {4{m1_cyc_i}};
                m1_dat_o = s_dat_i;
                m1_ack_o = ack1_s;
                m1_err_o = err_pend_s & ~ack1_s;
                wd_stb_s = m1_cyc_i & m1_stb_i;
            end
            ST_IDLE: begin
                wd_stb_s = 1'b0;
            end
            default: begin
                wd_stb_s = 1'b0;
            end
        endcase
    end

    assign gnt_o = gnt_r;

    wb_ack_watchdog #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .stb      (wd_stb_s),
        .ack      (s_ack_i),
        .clr      (grant_chg_s),
        .err_pend (err_pend_s)
    );

endmodule

// File: tb/tb_wishbone_2mst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wishbone_2mst_arbiter
// Directed bench for the two-master arbiter with a short watchdog (TIMEOUT=4).
// ---------------------------------------------------------------------------
module tb_wishbone_2mst_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic [1:0]  gnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wishbone_2mst_arbiter #(.TW(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i),
        .m0_we_i(m0_we_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_adr_i(m1_adr_i),
        .m1_we_i(m1_we_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hard stop if the run ever overruns.
    initial begin
        #100000;
        $display("FAIL run_timeout: got=overrun expected=finish");
        $fatal(1, "bench overran its time budget");
    end

    initial begin
        rst_n = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        m0_adr_i = 32'h0; m0_dat_i = 32'h0; m0_sel_i = 4'h0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        m1_adr_i = 32'h0; m1_dat_i = 32'h0; m1_sel_i = 4'h0;
        s_dat_i = 32'hDEAD_BEEF; s_ack_i = 1'b1;
        #12;
        // Reset state: everything quiet even with slave data/ack present.
        chk("rst_gnt", {30'h0, gnt_o}, 32'h0);
        chk("rst_s_cyc", {31'h0, s_cyc_o}, 32'h0);
        chk("rst_s_adr", s_adr_o, 32'h0);
        chk("rst_m0_dat", m0_dat_o, 32'h0);
        chk("rst_m1_dat", m1_dat_o, 32'h0);
        chk("rst_m0_ack", {31'h0, m0_ack_o}, 32'h0);
        s_ack_i = 1'b0;
        rst_n = 1'b1;

        // Single m0 write.
        step();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
        m0_adr_i = 32'h3002_0004; m0_dat_i = 32'h0000_A5A5; m0_sel_i = 4'hF;
        #1;
        chk("t1_gnt_wait", {30'h0, gnt_o}, 32'h0);
        chk("t1_s_cyc_wait", {31'h0, s_cyc_o}, 32'h0);
        step();
        chk("t1_gnt", {30'h0, gnt_o}, 32'h1);
        chk("t1_s_cyc", {31'h0, s_cyc_o}, 32'h1);
        chk("t1_s_stb", {31'h0, s_stb_o}, 32'h1);
        chk("t1_s_we", {31'h0, s_we_o}, 32'h1);
        chk("t1_s_adr", s_adr_o, 32'h3002_0004);
        chk("t1_s_dat", s_dat_o, 32'h0000_A5A5);
        chk("t1_s_sel", {28'h0, s_sel_o}, 32'hF);
        chk("t1_ack_noack", {31'h0, m0_ack_o}, 32'h0);
        s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
        #1;
        chk("t1_m0_ack", {31'h0, m0_ack_o}, 32'h1);
        chk("t1_m0_dat", m0_dat_o, 32'h1234_5678);
        chk("t1_m1_ack", {31'h0, m1_ack_o}, 32'h0);
        chk("t1_m1_dat", m1_dat_o, 32'h0);
        chk("t1_m1_err", {31'h0, m1_err_o}, 32'h0);
        step();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; s_ack_i = 1'b0;
        #1;
        chk("t1_gnt_hold", {30'h0, gnt_o}, 32'h1);
        chk("t1_s_cyc_gated", {31'h0, s_cyc_o}, 32'h0);
        step();
        chk("t1_gnt_idle", {30'h0, gnt_o}, 32'h0);

        // Simultaneous requests from reset, handoff, alternation.
        rst_n = 1'b0; #2; rst_n = 1'b1;
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        step();
        chk("t2_first", {30'h0, gnt_o}, 32'h1);
        m0_cyc_i = 1'b0;
        #1;
        chk("t2_hold", {30'h0, gnt_o}, 32'h1);
        step();
        chk("t2_handoff", {30'h0, gnt_o}, 32'h2);
        m1_cyc_i = 1'b0;
        step();
        chk("t2_idle_a", {30'h0, gnt_o}, 32'h0);
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        step();
        chk("t2_alt_01", {30'h0, gnt_o}, 32'h1);
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        step();
        chk("t2_idle_b", {30'h0, gnt_o}, 32'h0);
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        step();
        chk("t2_alt_10", {30'h0, gnt_o}, 32'h2);
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        step();
        chk("t2_idle_c", {30'h0, gnt_o}, 32'h0);

        // m0 locks the bus across three reads while m1 waits.
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        chk("t3_gnt", {30'h0, gnt_o}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            m0_stb_i = 1'b1; m0_we_i = 1'b0;
            m0_adr_i = 32'h3000_0000 + 32'(i * 4);
            s_dat_i = 32'hC0DE_0000 + 32'(i);
            s_ack_i = 1'b1;
            #1;
            chk("t3_lock", {30'h0, gnt_o}, 32'h1);
            chk("t3_s_adr", s_adr_o, 32'h3000_0000 + 32'(i * 4));
            chk("t3_m0_ack", {31'h0, m0_ack_o}, 32'h1);
            chk("t3_m0_dat", m0_dat_o, 32'hC0DE_0000 + 32'(i));
            chk("t3_m1_ack", {31'h0, m1_ack_o}, 32'h0);
            chk("t3_m1_dat", m1_dat_o, 32'h0);
            step();
        end
        m0_stb_i = 1'b0; m0_cyc_i = 1'b0; s_ack_i = 1'b0;
        #1;
        chk("t3_release_hold", {30'h0, gnt_o}, 32'h1);
        step();
        chk("t3_m1_gnt", {30'h0, gnt_o}, 32'h2);
        s_ack_i = 1'b1; s_dat_i = 32'h0BAD_F00D;
        #1;
        chk("t3_m1_ack", {31'h0, m1_ack_o}, 32'h1);
        chk("t3_m1_rdat", m1_dat_o, 32'h0BAD_F00D);
        chk("t3_m0_ack_off", {31'h0, m0_ack_o}, 32'h0);
        m1_stb_i = 1'b0; s_ack_i = 1'b0;
        step();

        // Watchdog: four stalled cycles then a single err cycle.
        m1_adr_i = 32'h3001_0000; m1_stb_i = 1'b1; m1_we_i = 1'b0;
        #1;
        chk("t4_err_c0", {31'h0, m1_err_o}, 32'h0);
        chk("t4_stb_c0", {31'h0, s_stb_o}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_err_stall", {31'h0, m1_err_o}, 32'h0);
            chk("t4_stb_stall", {31'h0, s_stb_o}, 32'h1);
            chk("t4_ack_stall", {31'h0, m1_ack_o}, 32'h0);
        end
        step();
        chk("t4_err_fire", {31'h0, m1_err_o}, 32'h1);
        chk("t4_stb_forced", {31'h0, s_stb_o}, 32'h0);
        chk("t4_cyc_forced", {31'h0, s_cyc_o}, 32'h0);
        chk("t4_ack_fire", {31'h0, m1_ack_o}, 32'h0);
        chk("t4_m0_err", {31'h0, m0_err_o}, 32'h0);
        step();
        chk("t4_err_once", {31'h0, m1_err_o}, 32'h0);
        chk("t4_stb_back", {31'h0, s_stb_o}, 32'h1);
        chk("t4_gnt", {30'h0, gnt_o}, 32'h2);
        m1_stb_i = 1'b0;
        step();

        // Ack on the last stalled cycle: no err follows.
        m1_stb_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5a_err_stall", {31'h0, m1_err_o}, 32'h0);
        end
        s_ack_i = 1'b1;
        #1;
        chk("t5a_ack", {31'h0, m1_ack_o}, 32'h1);
        chk("t5a_err", {31'h0, m1_err_o}, 32'h0);
        step();
        m1_stb_i = 1'b0; s_ack_i = 1'b0;
        #1;
        chk("t5a_err_after", {31'h0, m1_err_o}, 32'h0);
        step();

        // Ack arriving in the err cycle itself: ack wins, err suppressed.
        m1_stb_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5b_err_stall", {31'h0, m1_err_o}, 32'h0);
        end
        step();
        s_ack_i = 1'b1;
        #1;
        chk("t5b_ack", {31'h0, m1_ack_o}, 32'h1);
        chk("t5b_err", {31'h0, m1_err_o}, 32'h0);
        m1_stb_i = 1'b0; s_ack_i = 1'b0;
        step();

        // Asynchronous reset in the middle of an m1 transfer.
        m1_stb_i = 1'b1; s_ack_i = 1'b1; s_dat_i = 32'h5555_AAAA;
        #1;
        chk("t6_pre_ack", {31'h0, m1_ack_o}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_gnt", {30'h0, gnt_o}, 32'h0);
        chk("t6_s_cyc", {31'h0, s_cyc_o}, 32'h0);
        chk("t6_s_stb", {31'h0, s_stb_o}, 32'h0);
        chk("t6_s_adr", s_adr_o, 32'h0);
        chk("t6_m1_ack", {31'h0, m1_ack_o}, 32'h0);
        chk("t6_m1_dat", m1_dat_o, 32'h0);
        chk("t6_m1_err", {31'h0, m1_err_o}, 32'h0);
        rst_n = 1'b1;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h3003_0000;
        step();
        chk("t6_regrant", {30'h0, gnt_o}, 32'h1);
        chk("t6_s_adr_after", s_adr_o, 32'h3003_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
